// File: rtl/tick_bcd_counter.sv
// Stopwatch that counts rising edges of a slow divided clock as NUM_DIGITS BCD digits.
// Define SEVENSEG_EN to add the registered active-low 7-segment output oseg.
module tick_bcd_counter #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      iclk,
  input  logic                      reset,
  input  logic                      itick,
  input  logic                      istart,
  input  logic                      istop,
  input  logic                      iclear,
  output logic [4*NUM_DIGITS-1:0]   obcd,
  output logic                      orunning,
  output logic                      ocarry
`ifdef SEVENSEG_EN
  ,
  output logic [7*NUM_DIGITS-1:0]   oseg
`endif
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick_c;
  logic                   count_en_c;
  logic                   wrap_c;
  logic [BCD_W-1:0]       bcd_inc_c;
  logic [BCD_W-1:0]       bcd_nxt_c;
  logic                   carry_nxt_c;

  // itick synchronizer plus edge-detect history flop
  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], itick};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_c = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Run control; a clear holds the state so it never starts or stops the watch
  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      state_q  <= STOPPED;
      orunning <= 1'b0;
    end else if (!iclear) begin
      case (state_q)
        STOPPED: begin
          if (istart && !istop) begin
            state_q  <= RUNNING;
            orunning <= 1'b1;
          end
        end
        RUNNING: begin
          if (istop) begin
            state_q  <= STOPPED;
            orunning <= 1'b0;
          end
        end
        default: begin
          state_q  <= STOPPED;
          orunning <= 1'b0;
        end
      endcase
    end
  end

  // Ripple BCD increment; wrap_c set when every digit rolled over from 9
  always_comb begin
    logic carry;
    bcd_inc_c = obcd;
    carry     = 1'b1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (carry) begin
        if (obcd[4*k +: 4] == 4'd9) begin
          bcd_inc_c[4*k +: 4] = 4'd0;
        end else begin
          bcd_inc_c[4*k +: 4] = obcd[4*k +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    wrap_c = carry;
  end

  assign count_en_c = tick_c & (state_q == RUNNING) & ~istop;

  always_comb begin
    bcd_nxt_c   = obcd;
    carry_nxt_c = 1'b0;
    if (iclear) begin
      bcd_nxt_c = '0;
    end else if (count_en_c) begin
      bcd_nxt_c   = bcd_inc_c;
      carry_nxt_c = wrap_c;
    end
  end

  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      obcd   <= '0;
      ocarry <= 1'b0;
    end else begin
      obcd   <= bcd_nxt_c;
      ocarry <= carry_nxt_c;
    end
  end

`ifdef SEVENSEG_EN
  logic [7*NUM_DIGITS-1:0] seg_nxt_c;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Decode the next count so oseg lands on the same edge as obcd
  always_comb begin
    seg_nxt_c = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      seg_nxt_c[7*k +: 7] = seg7(bcd_nxt_c[4*k +: 4]);
    end
  end

  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      oseg <= {NUM_DIGITS{7'h40}};
    end else begin
      oseg <= seg_nxt_c;
    end
  end
`endif

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Self-checking bench for tick_bcd_counter: directed table, corner sequences, random run.
module tb_tick_bcd_counter;

  localparam int ND  = 4;
  localparam int SS  = 2;
  localparam int MOD = 10000;

  logic iclk = 1'b0;
  logic reset = 1'b1;
  logic itick = 1'b0;
  logic istart = 1'b0;
  logic istop = 1'b0;
  logic iclear = 1'b0;
  logic [4*ND-1:0] obcd;
  logic orunning;
  logic ocarry;
`ifdef SEVENSEG_EN
  logic [7*ND-1:0] oseg;
`endif

  int nchecks = 0;
  int nerr = 0;

  tick_bcd_counter #(.NUM_DIGITS(ND), .SYNC_STAGES(SS)) dut (
    .iclk(iclk),
    .reset(reset),
    .itick(itick),
    .istart(istart),
    .istop(istop),
    .iclear(iclear),
    .obcd(obcd),
    .orunning(orunning),
    .ocarry(ocarry)
`ifdef SEVENSEG_EN
    ,
    .oseg(oseg)
`endif
  );

  always #5 iclk = ~iclk;

  // Reference model: integer count, itick sample history, run flag
  int m_count = 0;
  bit m_run = 1'b0;
  bit m_carry = 1'b0;
  bit hist[$];

  always @(posedge iclk or posedge reset) begin
    if (reset) begin
      m_count = 0;
      m_run = 1'b0;
      m_carry = 1'b0;
      hist.delete();
      for (int i = 0; i <= SS; i++) hist.push_back(1'b0);
    end else begin
      bit t;
      // A tick is seen once itick was high SS samples ago and low the sample before
      t = hist[SS-1] && !hist[SS];
      hist.push_front(itick);
      void'(hist.pop_back());
      m_carry = 1'b0;
      if (iclear) m_count = 0;
      else if (t && m_run && !istop) begin
        m_carry = (m_count == MOD - 1);
        m_count = (m_count + 1) % MOD;
      end
      if (!iclear) begin
        if (m_run && istop) m_run = 1'b0;
        else if (!m_run && istart && !istop) m_run = 1'b1;
      end
    end
  end

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

`ifdef SEVENSEG_EN
  logic [6:0] segtab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  function automatic logic [7*ND-1:0] to_seg(input int v);
    logic [7*ND-1:0] r;
    int x;
    x = v;
    for (int k = 0; k < ND; k++) begin
      r[7*k +: 7] = segtab[x % 10];
      x = x / 10;
    end
    return r;
  endfunction
`endif

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // One iclk cycle: inputs set at a negedge, outputs compared with the model at the next negedge
  task automatic cyc();
    @(posedge iclk);
    @(negedge iclk);
    chk("model_obcd", obcd, to_bcd(m_count));
    chk("model_orunning", orunning, m_run);
    chk("model_ocarry", ocarry, m_carry);
`ifdef SEVENSEG_EN
    chk("model_oseg", oseg, to_seg(m_count));
`endif
  endtask

  task automatic apply_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      itick = 1'b1; cyc();
      itick = 1'b0; cyc();
    end
    cyc(); cyc();
  endtask

  typedef struct {
    string       name;
    bit          start;
    bit          stop;
    bit          clear;
    int          nticks;
    logic [15:0] exp_bcd;
    bit          exp_run;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"start12",   1'b1, 1'b0, 1'b0,   12, 16'h0012, 1'b1};
    vecs[1] = '{"clear",     1'b0, 1'b0, 1'b1,    0, 16'h0000, 1'b1};
    vecs[2] = '{"to41",      1'b0, 1'b0, 1'b0,   41, 16'h0041, 1'b1};
    vecs[3] = '{"stop",      1'b0, 1'b1, 1'b0,    5, 16'h0041, 1'b0};
    vecs[4] = '{"startstop", 1'b1, 1'b1, 1'b0,    3, 16'h0041, 1'b0};
    vecs[5] = '{"restart",   1'b1, 1'b0, 1'b0,  196, 16'h0237, 1'b1};
    vecs[6] = '{"clear2",    1'b0, 1'b0, 1'b1,    0, 16'h0000, 1'b1};
    vecs[7] = '{"to9998",    1'b0, 1'b0, 1'b0, 9998, 16'h9998, 1'b1};

    // Reset held with itick toggling: everything stays zero
    @(negedge iclk);
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) itick = ~itick;
      cyc();
      chk("rst_obcd", obcd, 16'h0000);
      chk("rst_run", orunning, 1'b0);
      chk("rst_carry", ocarry, 1'b0);
    end
    // Release with itick high: the resulting tick is not counted
    itick = 1'b1;
    reset = 1'b0;
    repeat (4) cyc();
    itick = 1'b0;
    cyc();
    apply_ticks(5);
    chk("idle_obcd", obcd, 16'h0000);

    for (int v = 0; v < 8; v++) begin
      istart = vecs[v].start;
      istop  = vecs[v].stop;
      iclear = vecs[v].clear;
      cyc();
      istart = 1'b0; istop = 1'b0; iclear = 1'b0;
      apply_ticks(vecs[v].nticks);
      chk({vecs[v].name, "_obcd"}, obcd, vecs[v].exp_bcd);
      chk({vecs[v].name, "_run"}, orunning, vecs[v].exp_run);
    end

    // Wrap from all-9s with a single-cycle carry
    apply_ticks(1);
    chk("pre_wrap", obcd, 16'h9999);
    itick = 1'b1; cyc();
    itick = 1'b0; cyc();
    cyc();
    chk("wrap_obcd", obcd, 16'h0000);
    chk("wrap_carry", ocarry, 1'b1);
    cyc();
    chk("wrap_carry_end", ocarry, 1'b0);
    chk("wrap_run", orunning, 1'b1);

    // istop coincident with a tick at 0041
    iclear = 1'b1; cyc(); iclear = 1'b0;
    apply_ticks(41);
    itick = 1'b1; cyc();
    itick = 1'b0; cyc();
    istop = 1'b1; cyc(); istop = 1'b0;
    cyc();
    chk("stoptick_obcd", obcd, 16'h0041);
    chk("stoptick_run", orunning, 1'b0);

    // iclear coincident with a tick at 0237, then latency of the next tick
    istart = 1'b1; cyc(); istart = 1'b0;
    iclear = 1'b1; cyc(); iclear = 1'b0;
    apply_ticks(237);
    chk("pre_clr", obcd, 16'h0237);
    itick = 1'b1; cyc();
    itick = 1'b0; cyc();
    iclear = 1'b1; cyc(); iclear = 1'b0;
    chk("clrtick_obcd", obcd, 16'h0000);
    chk("clrtick_run", orunning, 1'b1);
    cyc();
    itick = 1'b1; cyc();
    chk("lat_e1", obcd, 16'h0000);
    itick = 1'b0; cyc();
    chk("lat_e2", obcd, 16'h0000);
    cyc();
    chk("lat_e3", obcd, 16'h0001);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2, 0) == 0) itick = ~itick;
      istart = ($urandom_range(7, 0) == 0);
      istop  = ($urandom_range(15, 0) == 0);
      iclear = ($urandom_range(31, 0) == 0);
      cyc();
    end
    istart = 1'b0; istop = 1'b0; iclear = 1'b0; itick = 1'b0;
    cyc(); cyc(); cyc();

    // 0109 on the display, then async reset mid-count
    iclear = 1'b1; istart = 1'b1; cyc(); iclear = 1'b0; cyc(); istart = 1'b0;
    apply_ticks(109);
    chk("c109_obcd", obcd, 16'h0109);
`ifdef SEVENSEG_EN
    chk("c109_oseg", oseg, {7'h40, 7'h79, 7'h40, 7'h10});
`endif
    itick = 1'b1; cyc(); itick = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_obcd", obcd, 16'h0000);
    chk("async_run", orunning, 1'b0);
    chk("async_carry", ocarry, 1'b0);
`ifdef SEVENSEG_EN
    chk("async_oseg", oseg, {4{7'h40}});
`endif
    @(negedge iclk);
    cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    chk("post_rst_obcd", obcd, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
    $finish;
  end

endmodule
